bin_to_bcd_seq: RTL and testbench

Sequential double-dabble converter that sits directly downstream of the 16-bit result register. It takes the latched binary value, optionally treats it as two's complement, and produces a sign flag plus packed BCD digits for the seven-segment display driver. Conversion uses one shift per cycle over N cycles. The output holds the last result until a new conversion completes.

---
 rtl/bcd_pkg.sv | 19 +
 rtl/bcd_digit_adjust.sv | 15 +
 rtl/bin_to_bcd_seq.sv | 99 +++++++++
 tb/tb_bin_to_bcd_seq.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Also provides a helper to validate the digit count against the input width.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

  // Decimal digits of 2^n-1 is floor(n*log10(2))+1; log10(2) ~ 0.30103.
  function automatic int bcd_digits_needed(input int n);
    return (n * 30103) / 100000 + 1;
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 before
// the shift so that it carries correctly into the next decimal digit.
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [3:0] digit,
  output logic [3:0] adjusted
);

  always_comb begin
    adjusted = digit;
    if (digit >= BCD_ADJ_THRESH) adjusted = digit + BCD_ADJ_ADD;
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: one shift per cycle, optional two's
// complement input, sign flag plus packed BCD held until the next result.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int N      = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  signed_mode,
  input  logic [N-1:0]          bin,
  output logic                  busy,
  output logic                  done,
  output logic                  sign,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int CW = $clog2(N + 1);

  generate
    if (DIGITS < bcd_digits_needed(N)) begin : g_bad_digits
      $error("bin_to_bcd_seq: DIGITS too small for N");
    end
  endgenerate

  state_t               state, state_next;
  logic [CW-1:0]        count;
  logic [4*DIGITS-1:0]  scratch, scratch_adj;
  logic [N-1:0]         binreg;
  logic                 sign_pending;
  logic                 neg;

  assign neg  = signed_mode & bin[N-1];
  assign busy = (state != IDLE);

  genvar d;
  generate
    for (d = 0; d < DIGITS; d++) begin : g_adj
      bcd_digit_adjust u_adj (
        .digit    (scratch[4*d +: 4]),
        .adjusted (scratch_adj[4*d +: 4])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (count == CW'(1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath and output registers; the negated magnitude of the most
  // negative input is naturally 2^(N-1) when read back as unsigned.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count        <= '0;
      scratch      <= '0;
      binreg       <= '0;
      sign_pending <= 1'b0;
      done         <= 1'b0;
      sign         <= 1'b0;
      bcd          <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            binreg       <= neg ? (~bin + N'(1)) : bin;
            sign_pending <= neg;
            scratch      <= '0;
            count        <= CW'(N);
          end
        end
        SHIFT: begin
          {scratch, binreg} <= {scratch_adj, binreg} << 1;
          count             <= count - CW'(1);
        end
        DONE: begin
          bcd  <= scratch;
          sign <= sign_pending;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench: cycle-level transaction model compared every cycle,
// plus directed literal checks and randomized conversions.
module tb_bin_to_bcd_seq;

  localparam int N = 16;
  localparam int DIGITS = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        signed_mode = 1'b0;
  logic [15:0] bin = '0;
  logic        busy, done, sign;
  logic [19:0] bcd;

  int total = 0;
  int bad = 0;

  bin_to_bcd_seq #(.N(N), .DIGITS(DIGITS)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .signed_mode (signed_mode),
    .bin         (bin),
    .busy        (busy),
    .done        (done),
    .sign        (sign),
    .bcd         (bcd)
  );

  always #5 clk = ~clk;

  // Reference result from plain arithmetic: {sign, bcd}.
  function automatic logic [20:0] ref_result(input logic [15:0] b, input logic sm);
    int mag;
    logic [19:0] r;
    logic s;
    s   = sm && b[15];
    mag = s ? (65536 - int'(b)) : int'(b);
    r   = '0;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(mag % 10);
      mag = mag / 10;
    end
    return {s, r};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: a conversion occupies N+1 cycles after the start edge.
  int          m_left = 0;
  logic        m_done = 1'b0;
  logic [19:0] m_bcd = '0;
  logic        m_sign = 1'b0;
  logic [20:0] m_pend = '0;
  logic        armed = 1'b0;
  logic        prev_done = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_left = 0; m_done = 1'b0; m_bcd = '0; m_sign = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_left == 0) begin
        if (start) begin
          m_left = N + 1;
          m_pend = ref_result(bin, signed_mode);
        end
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_done = 1'b1;
          {m_sign, m_bcd} = m_pend;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      checkOutput("busy", 32'(busy), 32'(m_left > 0));
      checkOutput("done", 32'(done), 32'(m_done));
      checkOutput("bcd",  32'(bcd),  32'(m_bcd));
      checkOutput("sign", 32'(sign), 32'(m_sign));
      if (done && prev_done) checkOutput("done_twice", 32'(1), 32'(0));
      prev_done = done;
    end
  end

  // Caller sits at a negedge; start is presented for exactly one edge.
  task automatic applyStimulus(input logic [15:0] b, input logic sm);
    #1;
    bin = b; signed_mode = sm; start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0; bin = 16'($urandom); signed_mode = 1'($urandom);
  endtask

  task automatic waitDone(input int limit, output int cycles, output logic seen);
    cycles = 0; seen = 1'b0;
    while (!seen && cycles < limit) begin
      @(negedge clk);
      cycles++;
      if (done) seen = 1'b1;
    end
    if (!seen) checkOutput("done_timeout", 32'(0), 32'(1));
  endtask

  task automatic convertAndCheck(input string name, input logic [15:0] b, input logic sm,
                                 input logic [19:0] exp_bcd, input logic exp_sign);
    int cyc; logic seen;
    applyStimulus(b, sm);
    waitDone(40, cyc, seen);
    checkOutput({name, "_latency"}, 32'(cyc), 32'(N + 1));
    checkOutput({name, "_bcd"}, 32'(bcd), 32'(exp_bcd));
    checkOutput({name, "_sign"}, 32'(sign), 32'(exp_sign));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int cyc; logic seen; int dones;
    logic [15:0] rb; logic rsm; logic [20:0] rexp;

    repeat (2) @(negedge clk);
    checkOutput("reset_busy", 32'(busy), 32'(0));
    checkOutput("reset_done", 32'(done), 32'(0));
    checkOutput("reset_bcd",  32'(bcd),  32'(0));
    checkOutput("reset_sign", 32'(sign), 32'(0));
    reset = 1'b0;
    armed = 1'b1;
    @(negedge clk);

    convertAndCheck("d12345", 16'd12345, 1'b0, 20'h12345, 1'b0);
    convertAndCheck("ffff_u", 16'hFFFF, 1'b0, 20'h65535, 1'b0);
    convertAndCheck("ffff_s", 16'hFFFF, 1'b1, 20'h00001, 1'b1);
    convertAndCheck("min_s",  16'h8000, 1'b1, 20'h32768, 1'b1);
    convertAndCheck("zero_s", 16'h0000, 1'b1, 20'h00000, 1'b0);
    convertAndCheck("d999_s", 16'd999,  1'b1, 20'h00999, 1'b0);

    // Start while busy must be ignored; then restart right after done.
    applyStimulus(16'd999, 1'b0);
    repeat (4) @(negedge clk);
    applyStimulus(16'd1, 1'b0);
    dones = 0; cyc = 0; seen = 1'b0;
    while (!seen && cyc < 40) begin
      @(negedge clk); cyc++;
      if (done) begin seen = 1'b1; dones++; end
    end
    checkOutput("ignored_bcd", 32'(bcd), 32'h00999);
    checkOutput("ignored_ndone", 32'(dones), 32'(1));
    convertAndCheck("back2back", 16'd1, 1'b0, 20'h00001, 1'b0);

    // Mid-conversion reset aborts and clears the held result.
    applyStimulus(16'd4321, 1'b0);
    repeat (7) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    checkOutput("abort_busy", 32'(busy), 32'(0));
    checkOutput("abort_done", 32'(done), 32'(0));
    checkOutput("abort_bcd",  32'(bcd),  32'(0));
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) dones++;
    end
    checkOutput("abort_nodone", 32'(dones), 32'(0));
    convertAndCheck("after_reset", 16'd7, 1'b0, 20'h00007, 1'b0);

    // Randomized conversions, sometimes with a spurious start mid-flight.
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      case ($urandom_range(0, 4))
        0:       rb = 16'h8000 ^ 16'($urandom_range(0, 3));
        1:       rb = 16'hFFFF - 16'($urandom_range(0, 3));
        2:       rb = 16'($urandom_range(0, 20));
        default: rb = 16'($urandom);
      endcase
      rsm  = 1'($urandom);
      rexp = ref_result(rb, rsm);
      applyStimulus(rb, rsm);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 10)) @(negedge clk);
        #1 start = 1'b1; bin = 16'($urandom);
        @(negedge clk); #1 start = 1'b0;
      end
      waitDone(40, cyc, seen);
      checkOutput("rand_bcd",  32'(bcd),  32'(rexp[19:0]));
      checkOutput("rand_sign", 32'(sign), 32'(rexp[20]));
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
